// File: rtl/xe_pkg.sv
// Shared types and constants for the DEUNA/DELUA Unibus DMA master.
package xe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SETUP,
    ST_MSYN,
    ST_DESKEW2,
    ST_RELEASE,
    ST_END
  } xe_state_t;

  // Unibus C1:C0 cycle codes
  localparam logic [1:0] C_DATI  = 2'b00;
  localparam logic [1:0] C_DATO  = 2'b10;
  localparam logic [1:0] C_DATOB = 2'b11;

  // 'XD', nreg code 1, version 002
  localparam logic [31:0] XE_IDENT = 32'h5844_1002;

  // ARM register 1 bit positions (read and write share the top bits)
  localparam int R1_GO     = 31;
  localparam int R1_BUSY   = 31;
  localparam int R1_DATO   = 30;
  localparam int R1_BYTE   = 29;
  localparam int R1_BUSERR = 28;
  localparam int R1_GNTERR = 27;
  localparam int R1_DONE   = 26;

  // ARM register 3 bit positions
  localparam int R3_EN  = 31;
  localparam int R3_CLR = 0;

  // Counters stick at all-ones instead of wrapping
  function automatic logic [16:0] sat_inc(input logic [16:0] v);
    return (v == 17'h1ffff) ? v : v + 17'd1;
  endfunction

endpackage

// File: rtl/ub_master_cycle.sv
// Unibus master bus-cycle sequencer: drives address/control/data with BBSY,
// deskews into MSYN, waits for SSYN, deskews the read latch, then releases.
// Reusable by any NPR-capable device once it has won the grant.
module ub_master_cycle
  import xe_pkg::*;
#(
  parameter int DESKEW  = 15,
  parameter int TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        abort,
  input  logic        start,
  input  logic [17:0] addr,
  input  logic [1:0]  code,
  input  logic [15:0] wdata,
  input  logic        ssyn,
  input  logic [15:0] din,
  output logic        bbsy,
  output logic        msyn,
  output logic [17:0] a,
  output logic [1:0]  c,
  output logic [15:0] d,
  output logic [15:0] rdata,
  output logic        fin,
  output logic        err
);

  localparam logic [16:0] DSK_LAST = 17'(DESKEW - 1);
  localparam logic [16:0] TMO_LAST = 17'(TIMEOUT - 1);

  xe_state_t   phase;
  logic [16:0] cnt;

  // Read data is kept across INIT so software still sees the last word read
  always_ff @(posedge clk) begin
    if (rst)
      rdata <= '0;
    else if (!abort && phase == ST_DESKEW2 && cnt >= DSK_LAST && c == C_DATI)
      rdata <= din;
  end

  // Bus-cycle sequencer; INIT drops every bus line in the same clock
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      phase <= ST_IDLE;
      cnt   <= '0;
      bbsy  <= 1'b0;
      msyn  <= 1'b0;
      a     <= '0;
      c     <= '0;
      d     <= '0;
      fin   <= 1'b0;
      err   <= 1'b0;
    end else begin
      fin <= 1'b0;
      case (phase)
        ST_IDLE: if (start) begin
          a     <= addr;
          c     <= code;
          d     <= wdata;
          bbsy  <= 1'b1;
          err   <= 1'b0;
          cnt   <= '0;
          phase <= ST_SETUP;
        end
        ST_SETUP: if (cnt >= DSK_LAST) begin
          msyn  <= 1'b1;
          cnt   <= '0;
          phase <= ST_MSYN;
        end else cnt <= sat_inc(cnt);
        ST_MSYN: if (ssyn) begin
          cnt   <= '0;
          phase <= ST_DESKEW2;
        end else if (cnt >= TMO_LAST) begin
          err   <= 1'b1;
          msyn  <= 1'b0;
          cnt   <= '0;
          phase <= ST_RELEASE;
        end else cnt <= sat_inc(cnt);
        ST_DESKEW2: if (cnt >= DSK_LAST) begin
          msyn  <= 1'b0;
          cnt   <= '0;
          phase <= ST_RELEASE;
        end else cnt <= sat_inc(cnt);
        ST_RELEASE: if (!ssyn || cnt >= TMO_LAST) begin
          if (ssyn) err <= 1'b1;
          a     <= '0;
          c     <= '0;
          d     <= '0;
          bbsy  <= 1'b0;
          fin   <= 1'b1;
          cnt   <= '0;
          phase <= ST_IDLE;
        end else cnt <= sat_inc(cnt);
        default: phase <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/xe_dma.sv
// DEUNA/DELUA NPR DMA master: ARM-visible command registers, NPR/NPG
// arbitration with grant timeout, and one Unibus transfer per command.
module xe_dma
  import xe_pkg::*;
#(
  parameter int DESKEW  = 15,
  parameter int TIMEOUT = 1000,
  parameter int GNTTMO  = 100000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [1:0]  armraddr,
  input  logic [1:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  output logic        armintrq,
  input  logic        init_in_h,
  output logic        npr_out_h,
  input  logic        npg_in_h,
  output logic        bbsy_out_h,
  output logic [17:0] a_out_h,
  output logic [1:0]  c_out_h,
  output logic [15:0] d_out_h,
  output logic        msyn_out_h,
  input  logic        ssyn_in_h,
  input  logic [15:0] d_in_h
);

  localparam logic [16:0] GNT_LAST = 17'(GNTTMO - 1);

  // ST_SETUP here means "bus cycle handed to the sequencer"; the finer
  // SETUP/MSYN/DESKEW2/RELEASE phases live inside ub_master_cycle.
  xe_state_t   state;
  logic [16:0] gcnt;
  logic        enable, done, buserr, gnterr, dato, bmode;
  logic [17:0] addr;
  logic [15:0] wdata, rdata;
  logic        busy, cyc_start, cyc_fin, cyc_err;
  logic [1:0]  cyc_code;
  logic [15:0] cyc_wdata;
  logic        unused_wbits;

  assign unused_wbits = ^armwdata[28:18];
  assign busy      = (state != ST_IDLE);
  assign armintrq  = done;
  assign cyc_start = (state == ST_REQ) && npg_in_h && !ssyn_in_h && !init_in_h;
  assign cyc_code  = dato ? {1'b1, bmode} : C_DATI;
  assign cyc_wdata = dato ? wdata : 16'h0;

  // ARM register read mux
  always_comb begin
    armrdata = '0;
    case (armraddr)
      2'd0:    armrdata = XE_IDENT;
      2'd1:    armrdata = {busy, dato, bmode, buserr, gnterr, done, 8'b0, addr};
      2'd2:    armrdata = {rdata, wdata};
      default: armrdata = {enable, 31'b0};
    endcase
  end

  // Register writes first, then FSM and INIT, so flag sets win over clears
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      gcnt      <= '0;
      enable    <= 1'b0;
      done      <= 1'b0;
      buserr    <= 1'b0;
      gnterr    <= 1'b0;
      dato      <= 1'b0;
      bmode     <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      npr_out_h <= 1'b0;
    end else begin
      if (armwrite) begin
        case (armwaddr)
          2'd1: if (state == ST_IDLE && enable && !init_in_h) begin
            dato  <= armwdata[R1_DATO];
            bmode <= armwdata[R1_BYTE];
            addr  <= armwdata[17:0];
            if (armwdata[R1_GO]) begin
              done   <= 1'b0;
              buserr <= 1'b0;
              gnterr <= 1'b0;
              // word access at an odd address never reaches the bus
              if (!armwdata[R1_BYTE] && armwdata[0]) begin
                buserr <= 1'b1;
                done   <= 1'b1;
              end else begin
                state     <= ST_REQ;
                npr_out_h <= 1'b1;
                gcnt      <= '0;
              end
            end
          end
          2'd2: if (!msyn_out_h) wdata <= armwdata[15:0];
          2'd3: begin
            enable <= armwdata[R3_EN];
            if (armwdata[R3_CLR]) begin
              done   <= 1'b0;
              buserr <= 1'b0;
              gnterr <= 1'b0;
            end
          end
          default: ;
        endcase
      end

      case (state)
        ST_REQ: if (cyc_start) begin
          npr_out_h <= 1'b0;
          state     <= ST_SETUP;
        end else if (gcnt >= GNT_LAST) begin
          gnterr    <= 1'b1;
          npr_out_h <= 1'b0;
          state     <= ST_END;
        end else gcnt <= sat_inc(gcnt);
        ST_SETUP: if (cyc_fin) begin
          if (cyc_err) buserr <= 1'b1;
          state <= ST_END;
        end
        ST_END: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: ;
      endcase

      if (init_in_h) begin
        npr_out_h <= 1'b0;
        gcnt      <= '0;
        state     <= ST_IDLE;
        if (busy) begin
          buserr <= 1'b1;
          done   <= 1'b1;
        end
      end
    end
  end

  ub_master_cycle #(.DESKEW(DESKEW), .TIMEOUT(TIMEOUT)) u_cyc (
    .clk   (CLOCK),
    .rst   (RESET),
    .abort (init_in_h),
    .start (cyc_start),
    .addr  (addr),
    .code  (cyc_code),
    .wdata (cyc_wdata),
    .ssyn  (ssyn_in_h),
    .din   (d_in_h),
    .bbsy  (bbsy_out_h),
    .msyn  (msyn_out_h),
    .a     (a_out_h),
    .c     (c_out_h),
    .d     (d_out_h),
    .rdata (rdata),
    .fin   (cyc_fin),
    .err   (cyc_err)
  );

endmodule
